// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus encodings: arbiter states, master instruction codes, default lengths
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] INSTR_READ = 2'b11;

    localparam int DATA_LEN  = 8;
    localparam int BURST_LEN = 12;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select, searching upward from last_id+1
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_W-1:0]        last_id,
    output logic [ID_W-1:0]        winner,
    output logic                   valid
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // the previous owner is visited last, so it waits behind every other requester
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last_id) + i) % NUM_MASTERS;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin serial bus arbiter with release turnaround; ARB_TIMEOUT_EN enables grant timeout
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ID_W           = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [ID_W-1:0]        grant_id_d;
    logic                   busy_d;
    logic [ID_W-1:0]        last_id, last_id_d;
    logic [ID_W-1:0]        winner;
    logic                   pick_valid;
    logic                   timeout_hit;
    logic                   release_c;

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .ID_W       (ID_W)
    ) u_picker (
        .req    (req),
        .last_id(last_id),
        .winner (winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            last_id  <= ID_W'(NUM_MASTERS - 1);
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            grant_id <= grant_id_d;
            bus_busy <= busy_d;
            last_id  <= last_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        grant_id_d = grant_id;
        busy_d     = bus_busy;
        last_id_d  = last_id;
        release_c  = done[grant_id] || !req[grant_id] || timeout_hit;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    busy_d          = 1'b1;
                    state_d         = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (release_c) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    last_id_d = grant_id;
                    state_d   = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             tmo_d;

    assign timeout_hit = (hold_cnt == HOLD_LAST);
    // done and req drop outrank the timeout, so the error only flags a genuine stall
    assign tmo_d = (state_q == ARB_GRANT) && !done[grant_id] && req[grant_id] && timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_d;
            if (state_q != ARB_GRANT) begin
                hold_cnt <= '0;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter (NUM_MASTERS=2, TIMEOUT_CYCLES=16)
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] done = 2'b00;
    logic [1:0] grant;
    logic [0:0] grant_id;
    logic       bus_busy;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(
        .NUM_MASTERS   (2),
        .ID_W          (1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (grant == 2'b11) begin
            failures++;
            $display("FAIL onehot actual=%b required=one-hot or zero", grant);
        end
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] grant;
        logic       busy;
        logic       id;
    } vec_t;

    vec_t vecs[22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        done  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int z;
        int tmo_seen;
        int owner;
        int bad;

        // single request, re-request, contention with non-owner done, withdrawal
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 2'b10, 2'b01, 1'b1, 1'b0};
        vecs[7]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b1};
        vecs[10] = '{2'b11, 2'b10, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b1};
        vecs[16] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[17] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[18] = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[19] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[20] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[21] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

        reset = 1'b1;
        #12;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(bus_busy), 32'h0);
        chk("reset_id", 32'(grant_id), 32'h0);
        chk("reset_tmo", 32'(timeout_err), 32'h0);
        do_reset();

        for (int i = 0; i < 22; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_tmo", i), 32'(timeout_err), 32'h0);
            if (vecs[i].busy)
                chk($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].id));
        end
        done = 2'b00;

        // contention: owners alternate, two idle cycles between owners
        do_reset();
        req = 2'b11;
        cnt = 0;
        while (grant == 2'b00 && cnt < 10) begin
            tick();
            cnt++;
        end
        for (int g = 0; g < 4; g++) begin
            owner = g % 2;
            chk($sformatf("rr%0d_owner", g), 32'(grant), 32'(2'b01 << owner));
            chk($sformatf("rr%0d_id", g), 32'(grant_id), 32'(owner));
            bad = 0;
            repeat (9) begin
                tick();
                if (grant != (2'b01 << owner)) bad++;
            end
            chk($sformatf("rr%0d_hold", g), 32'(bad), 32'h0);
            done = grant;
            tick();
            done = 2'b00;
            z = (grant == 2'b00) ? 1 : 0;
            cnt = 0;
            while (grant == 2'b00 && cnt < 10) begin
                tick();
                cnt++;
                if (grant == 2'b00) z++;
            end
            chk($sformatf("rr%0d_gap", g), 32'(z), 32'd2);
        end

        // master 0 stalls without done
        do_reset();
        req = 2'b11;
        tick();
        chk("to_first", 32'(grant), 32'h1);
        cnt = 1;
        tmo_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (grant != 2'b01) break;
            cnt++;
            if (timeout_err) tmo_seen++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_hold_cycles", 32'(cnt), 32'd16);
        chk("to_early_pulse", 32'(tmo_seen), 32'd0);
        chk("to_pulse", 32'(timeout_err), 32'h1);
        chk("to_grant_drop", 32'(grant), 32'h0);
        tick();
        chk("to_pulse_end", 32'(timeout_err), 32'h0);
        tick();
        chk("to_next_owner", 32'(grant), 32'h2);
`else
        chk("to_hold_forever", 32'(cnt), 32'd41);
        chk("to_never_pulse", 32'(tmo_seen), 32'd0);
        chk("to_still_owner", 32'(grant), 32'h1);
`endif

        // done lands on the final timeout cycle
        do_reset();
        req = 2'b01;
        tick();
        repeat (15) tick();
        chk("col_pre_grant", 32'(grant), 32'h1);
        done = 2'b01;
        tick();
        done = 2'b00;
        chk("col_release", 32'(grant), 32'h0);
        chk("col_no_tmo", 32'(timeout_err), 32'h0);
        tick();
        chk("col_no_tmo_late", 32'(timeout_err), 32'h0);

        // asynchronous reset while master 1 owns the bus
        do_reset();
        req = 2'b10;
        tick();
        chk("ar_grant", 32'(grant), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_grant_drop", 32'(grant), 32'h0);
        chk("ar_busy_drop", 32'(bus_busy), 32'h0);
        req = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ar_first_owner", 32'(grant), 32'h1);
        chk("ar_first_id", 32'(grant_id), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
